reg_file_scoreboard: RTL and testbench

Parametrised register file for the RISC-V pipeline: configurable data width, register count and number of read ports, hardwired-zero register 0, and same-cycle write-to-read bypass. It also keeps a per-register busy scoreboard. Issue marks a destination busy, writeback clears it, and issue is stalled on a write-after-write hazard. It sits between decode/issue, which reads operands and allocates destinations, and writeback, which returns results.

---
 rtl/reg_file_scoreboard.sv | 100 ++++++++++
 tb/tb_reg_file_scoreboard.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_scoreboard.sv
// Register file with hardwired-zero x0, optional same-cycle writeback-to-read
// forwarding, and a per-register busy scoreboard with a live busy count.
module reg_file_scoreboard #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned NRD    = 2,
  parameter int unsigned BYPASS = 1,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   Rd_Addr,
  output logic [NRD*XLEN-1:0] Rd_Data,
  output logic [NRD-1:0]      Rd_Busy,
  input  logic                Wr_En,
  input  logic [AW-1:0]       Wr_Addr,
  input  logic [XLEN-1:0]     Wr_Data,
  input  logic                Alloc_En,
  input  logic [AW-1:0]       Alloc_Addr,
  output logic                Alloc_Stall,
  output logic [AW:0]         Busy_Count
);

  localparam int unsigned CW = AW + 1;

  logic [XLEN-1:0]  r_rf [NREGS];
  logic [NREGS-1:0] r_busy;
  logic [CW-1:0]    r_cnt;

  logic w_wr_live;
  logic w_alloc_live;
  logic w_wr_alloc_same;
  logic w_stall;
  logic w_alloc_acc;
  logic w_inc;
  logic w_dec;

  // Hazard check and scoreboard bookkeeping for this cycle's issue/writeback.
  // x0 never participates, so a write or allocation to it is inert.
  always_comb begin
    w_wr_live       = Wr_En && (Wr_Addr != '0);
    w_alloc_live    = Alloc_En && (Alloc_Addr != '0);
    w_wr_alloc_same = Wr_En && (Wr_Addr == Alloc_Addr);
    // A writeback landing on the busy destination this cycle frees it in time.
    w_stall         = w_alloc_live && r_busy[Alloc_Addr] && !w_wr_alloc_same;
    w_alloc_acc     = w_alloc_live && !w_stall;
    w_inc           = w_alloc_acc && !r_busy[Alloc_Addr];
    // A writeback re-allocated in the same cycle leaves its busy bit set.
    w_dec           = w_wr_live && r_busy[Wr_Addr] && !(w_alloc_acc && w_wr_alloc_same);
  end

  assign Alloc_Stall = !rst && w_stall;
  assign Busy_Count  = rst ? '0 : r_cnt;

  // Independent read ports with x0 forcing and optional writeback forwarding.
  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0]   w_addr;
    logic [XLEN-1:0] w_data;
    logic            w_busy;

    assign w_addr = Rd_Addr[gi*AW +: AW];

    // Per-port operand select; reset forces a clean zero view.
    always_comb begin
      w_data = r_rf[w_addr];
      w_busy = r_busy[w_addr];
      if (rst || (w_addr == '0)) begin
        w_data = '0;
        w_busy = 1'b0;
      end else if ((BYPASS != 0) && Wr_En && (Wr_Addr == w_addr)) begin
        w_data = Wr_Data;
        w_busy = w_alloc_acc && (Alloc_Addr == w_addr);
      end
    end

    assign Rd_Data[gi*XLEN +: XLEN] = w_data;
    assign Rd_Busy[gi]              = w_busy;
  end

  // Register file, busy bits and busy count; allocation wins over writeback clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_rf[i] <= '0;
      end
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_wr_live) begin
        r_rf[Wr_Addr]   <= Wr_Data;
        r_busy[Wr_Addr] <= 1'b0;
      end
      if (w_alloc_acc) begin
        r_busy[Alloc_Addr] <= 1'b1;
      end
      r_cnt <= r_cnt + CW'(w_inc) - CW'(w_dec);
    end
  end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Bench for reg_file_scoreboard: a default 32x32 forwarding instance and a
// 64-bit, 16-entry, 3-port non-forwarding instance, both checked every cycle
// against an array-based model of the architectural rules.
module tb_reg_file_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: XLEN=32, NREGS=32, NRD=2, BYPASS=1
  logic        a_rst;
  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic        a_we;
  logic [4:0]  a_wa;
  logic [31:0] a_wd;
  logic        a_ae;
  logic [4:0]  a_aa;
  logic        a_stall;
  logic [5:0]  a_cnt;

  // Instance B: XLEN=64, NREGS=16, NRD=3, BYPASS=0
  logic         b_rst;
  logic [11:0]  b_rd_addr;
  logic [191:0] b_rd_data;
  logic [2:0]   b_rd_busy;
  logic         b_we;
  logic [3:0]   b_wa;
  logic [63:0]  b_wd;
  logic         b_ae;
  logic [3:0]   b_aa;
  logic         b_stall;
  logic [4:0]   b_cnt;

  reg_file_scoreboard #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1)) u_a (
    .clk(clk), .rst(a_rst), .Rd_Addr(a_rd_addr), .Rd_Data(a_rd_data), .Rd_Busy(a_rd_busy),
    .Wr_En(a_we), .Wr_Addr(a_wa), .Wr_Data(a_wd), .Alloc_En(a_ae), .Alloc_Addr(a_aa),
    .Alloc_Stall(a_stall), .Busy_Count(a_cnt)
  );

  reg_file_scoreboard #(.XLEN(64), .NREGS(16), .NRD(3), .BYPASS(0)) u_b (
    .clk(clk), .rst(b_rst), .Rd_Addr(b_rd_addr), .Rd_Data(b_rd_data), .Rd_Busy(b_rd_busy),
    .Wr_En(b_we), .Wr_Addr(b_wa), .Wr_Data(b_wd), .Alloc_En(b_ae), .Alloc_Addr(b_aa),
    .Alloc_Stall(b_stall), .Busy_Count(b_cnt)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Architectural model: contents and busy flags per instance.
  logic [63:0] m_rf   [2][32];
  bit          m_busy [2][32];

  function automatic int nregs(input int k);
    return (k == 0) ? 32 : 16;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Compare every output of both instances with the model, then advance one clock.
  task automatic step();
    bit          s_rst [2];
    bit          s_we  [2];
    bit          s_acc [2];
    int          s_wa  [2];
    int          s_aa  [2];
    logic [63:0] s_wd  [2];
    bit          ae, st, eb;
    int          nd, bp, cnt, ra;
    logic [63:0] ed, gd;
    logic        gb, gs;
    logic [63:0] gc;
    #1;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        s_rst[k] = a_rst; s_we[k] = a_we; s_wa[k] = int'(a_wa); s_wd[k] = 64'(a_wd);
        ae = a_ae; s_aa[k] = int'(a_aa); nd = 2; bp = 1; gs = a_stall; gc = 64'(a_cnt);
      end else begin
        s_rst[k] = b_rst; s_we[k] = b_we; s_wa[k] = int'(b_wa); s_wd[k] = b_wd;
        ae = b_ae; s_aa[k] = int'(b_aa); nd = 3; bp = 0; gs = b_stall; gc = 64'(b_cnt);
      end
      st = !s_rst[k] && ae && s_aa[k] != 0 && m_busy[k][s_aa[k]] &&
           !(s_we[k] && s_wa[k] == s_aa[k]);
      s_acc[k] = !s_rst[k] && ae && !st && s_aa[k] != 0;
      for (int i = 0; i < nd; i++) begin
        if (k == 0) begin
          ra = int'(a_rd_addr[i*5 +: 5]); gd = 64'(a_rd_data[i*32 +: 32]); gb = a_rd_busy[i];
        end else begin
          ra = int'(b_rd_addr[i*4 +: 4]); gd = b_rd_data[i*64 +: 64]; gb = b_rd_busy[i];
        end
        if (s_rst[k] || ra == 0) begin
          ed = '0; eb = 1'b0;
        end else if (bp != 0 && s_we[k] && s_wa[k] == ra) begin
          ed = s_wd[k]; eb = s_acc[k] && s_aa[k] == ra;
        end else begin
          ed = m_rf[k][ra]; eb = m_busy[k][ra];
        end
        check($sformatf("%s.rd_data%0d", k ? "B" : "A", i), gd, ed);
        check($sformatf("%s.rd_busy%0d", k ? "B" : "A", i), 64'(gb), 64'(eb));
      end
      check($sformatf("%s.alloc_stall", k ? "B" : "A"), 64'(gs), 64'(st));
      cnt = 0;
      if (!s_rst[k]) for (int j = 0; j < nregs(k); j++) cnt += int'(m_busy[k][j]);
      check($sformatf("%s.busy_count", k ? "B" : "A"), gc, 64'(cnt));
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (s_rst[k]) begin
        for (int j = 0; j < 32; j++) begin m_rf[k][j] = '0; m_busy[k][j] = 1'b0; end
      end else begin
        if (s_we[k] && s_wa[k] != 0) begin
          m_rf[k][s_wa[k]] = s_wd[k];
          m_busy[k][s_wa[k]] = 1'b0;
        end
        if (s_acc[k]) m_busy[k][s_aa[k]] = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    a_we = 1'b0; a_ae = 1'b0; b_we = 1'b0; b_ae = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 32; j++) begin m_rf[k][j] = '0; m_busy[k][j] = 1'b0; end
    a_rst = 1'b1; b_rst = 1'b1; idle();
    a_rd_addr = '0; a_wa = '0; a_wd = '0; a_aa = '0;
    b_rd_addr = '0; b_wa = '0; b_wd = '0; b_aa = '0;
    @(negedge clk);
    step(); step();
    a_rst = 1'b0; b_rst = 1'b0;

    // Reset discards a written value.
    a_we = 1'b1; a_wa = 5'd5; a_wd = 32'hDEADBEEF; step();
    idle(); a_rd_addr = {5'd5, 5'd5}; a_rst = 1'b1; step();
    a_rst = 1'b0;
    #1;
    check("rst_x5_data", 64'(a_rd_data[31:0]), 64'h0);
    check("rst_x5_busy", 64'(a_rd_busy[0]), 64'h0);
    check("rst_count", 64'(a_cnt), 64'h0);
    step();

    // x0 ignores writes and allocations.
    a_we = 1'b1; a_wa = 5'd0; a_wd = 32'h1234; step();
    idle(); a_ae = 1'b1; a_aa = 5'd0;
    #1; check("x0_alloc_stall", 64'(a_stall), 64'h0);
    step();
    idle(); a_rd_addr = '0;
    #1;
    check("x0_data", 64'(a_rd_data[31:0]), 64'h0);
    check("x0_count", 64'(a_cnt), 64'h0);
    step();

    // Scoreboard round trip on x7.
    a_ae = 1'b1; a_aa = 5'd7; step();
    idle(); a_rd_addr = {5'd0, 5'd7};
    #1;
    check("x7_busy_set", 64'(a_rd_busy[0]), 64'h1);
    check("x7_count1", 64'(a_cnt), 64'h1);
    a_ae = 1'b1; a_aa = 5'd7;
    #1; check("x7_waw_stall", 64'(a_stall), 64'h1);
    step();
    idle(); a_we = 1'b1; a_wa = 5'd7; a_wd = 32'hA5A5A5A5; step();
    idle();
    #1;
    check("x7_busy_clr", 64'(a_rd_busy[0]), 64'h0);
    check("x7_data", 64'(a_rd_data[31:0]), 64'hA5A5A5A5);
    check("x7_count0", 64'(a_cnt), 64'h0);
    step();

    // Forwarding on A versus none on B.
    a_we = 1'b1; a_wa = 5'd3; a_wd = 32'h11;
    b_we = 1'b1; b_wa = 4'd3; b_wd = 64'h11; step();
    a_wd = 32'h22; b_wd = 64'h22;
    a_rd_addr = {5'd3, 5'd3}; b_rd_addr = {4'd3, 4'd3, 4'd3};
    #1;
    check("byp_a_p0", 64'(a_rd_data[31:0]), 64'h22);
    check("byp_a_p1", 64'(a_rd_data[63:32]), 64'h22);
    check("byp_a_busy", 64'(a_rd_busy), 64'h0);
    check("nobyp_b_p2", b_rd_data[191:128], 64'h11);
    step();

    // Simultaneous allocation and writeback on busy x9.
    idle(); a_ae = 1'b1; a_aa = 5'd9; step();
    a_we = 1'b1; a_wa = 5'd9; a_wd = 32'h55;
    #1; check("x9_no_stall", 64'(a_stall), 64'h0);
    step();
    idle(); a_rd_addr = {5'd0, 5'd9};
    #1;
    check("x9_data", 64'(a_rd_data[31:0]), 64'h55);
    check("x9_busy", 64'(a_rd_busy[0]), 64'h1);
    check("x9_count", 64'(a_cnt), 64'h1);
    step();
    a_we = 1'b1; a_wa = 5'd9; a_wd = 32'h66; step();
    idle();

    // Fill and drain every allocatable register of B.
    for (int r = 1; r < 16; r++) begin b_ae = 1'b1; b_aa = 4'(r); step(); end
    idle();
    #1; check("b_full_count", 64'(b_cnt), 64'd15);
    step();
    for (int r = 15; r >= 1; r--) begin
      b_we = 1'b1; b_wa = 4'(r); b_wd = {32'hC0DE0000 | 32'(r), 32'(r * 3)}; step();
    end
    idle();
    #1; check("b_empty_count", 64'(b_cnt), 64'd0);
    step();
    for (int r = 1; r < 16; r++) begin
      b_rd_addr = {4'(r), 4'(r), 4'(r)};
      #1; check($sformatf("b_x%0d_val", r), b_rd_data[63:0], {32'hC0DE0000 | 32'(r), 32'(r * 3)});
      step();
    end

    // Randomized traffic with occasional resets and a bias toward low registers.
    for (int c = 0; c < 3000; c++) begin
      a_rst = ($urandom_range(0, 199) == 0);
      b_rst = ($urandom_range(0, 199) == 0);
      a_we = 1'($urandom_range(0, 1)); a_ae = 1'($urandom_range(0, 1));
      b_we = 1'($urandom_range(0, 1)); b_ae = 1'($urandom_range(0, 1));
      a_wa = 5'($urandom_range(0, $urandom_range(0, 1) ? 7 : 31));
      a_aa = 5'($urandom_range(0, $urandom_range(0, 1) ? 7 : 31));
      b_wa = 4'($urandom_range(0, $urandom_range(0, 1) ? 5 : 15));
      b_aa = 4'($urandom_range(0, $urandom_range(0, 1) ? 5 : 15));
      a_wd = $urandom;
      b_wd = {$urandom, $urandom};
      a_rd_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 31))};
      b_rd_addr = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
